// File: rtl/countdown_timer_if.sv
// Load handshake and status bundle for countdown_timer.
// The master side offers start values and controls; the slave side is the timer.
interface countdown_timer_if #(parameter int WIDTH = 8);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;
  logic             auto_reload;
  logic             enable;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_value, auto_reload, enable, abort,
    input  load_ready, count, busy, done
  );

  modport slave (
    input  load_valid, load_value, auto_reload, enable, abort,
    output load_ready, count, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter that pulses done at terminal count, with optional
// reload of the last start value for periodic ticks.
//
// state | meaning
// IDLE  | waiting for a start value; load_ready high, count is 0
// RUN   | counting down on enabled cycles; busy high
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  countdown_timer_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          if (bus.load_value != '0) begin
            count_d  = bus.load_value;
            reload_d = bus.load_value;
            state_d  = RUN;
          end else begin
            // zero-length countdown completes immediately
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (bus.enable) begin
          if (count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
          end else if (count_q == WIDTH'(1)) begin
            done_d = 1'b1;
            if (bus.auto_reload) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  assign bus.load_ready = (state_q == IDLE);
  assign bus.busy       = (state_q == RUN);
  assign bus.count      = count_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with hand-computed expected values.
module tb_countdown_timer;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_mis = 0;

  countdown_timer_if #(.WIDTH(8)) bus ();

  countdown_timer #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int v, input bit ar);
    bus.load_valid  = 1'b1;
    bus.load_value  = 8'(v);
    bus.auto_reload = ar;
    tick();
    bus.load_valid  = 1'b0;
  endtask

  task automatic chk_status(input string tag, input int c, input bit b, input bit d, input bit r);
    chk({tag, ".count"}, 32'(bus.count), 32'(c));
    chk({tag, ".busy"},  32'(bus.busy),  32'(b));
    chk({tag, ".done"},  32'(bus.done),  32'(d));
    chk({tag, ".ready"}, 32'(bus.load_ready), 32'(r));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "bench time limit");
  end

  initial begin
    int ar_cnt [10];
    int tog_en [6];
    int tog_cnt[6];
    int steps;

    ar_cnt  = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2};
    tog_en  = '{1, 0, 0, 1, 1, 1};
    tog_cnt = '{3, 3, 3, 2, 1, 0};

    reset           = 1'b1;
    bus.load_valid  = 1'b0;
    bus.load_value  = '0;
    bus.auto_reload = 1'b0;
    bus.enable      = 1'b0;
    bus.abort       = 1'b0;
    tick();
    tick();
    chk_status("reset", 0, 0, 0, 1);
    reset = 1'b0;

    // single countdown of 5
    bus.enable = 1'b1;
    load(5, 0);
    chk_status("ld5", 5, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ld5.cnt", 32'(bus.count), 32'(4 - i));
      chk("ld5.nodone", 32'(bus.done), 0);
    end
    tick();
    chk_status("ld5.term", 0, 0, 1, 1);
    tick();
    chk("ld5.after", 32'(bus.done), 0);

    // periodic reload of 3
    load(3, 1);
    chk("ar3.ld", 32'(bus.count), 3);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("ar3.cnt", 32'(bus.count), 32'(ar_cnt[i]));
      chk("ar3.done", 32'(bus.done), (ar_cnt[i] == 3) ? 32'd1 : 32'd0);
      chk("ar3.busy", 32'(bus.busy), 1);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.auto_reload = 1'b0;
    chk_status("ar3.abort", 0, 0, 0, 1);

    // enable toggling pauses the count
    load(4, 0);
    chk("tog.ld", 32'(bus.count), 4);
    for (int i = 0; i < 6; i++) begin
      bus.enable = tog_en[i][0];
      tick();
      chk("tog.cnt", 32'(bus.count), 32'(tog_cnt[i]));
      chk("tog.done", 32'(bus.done), (i == 5) ? 32'd1 : 32'd0);
    end
    bus.enable = 1'b1;
    tick();
    chk("tog.after", 32'(bus.done), 0);

    // abort mid-count
    load(6, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("ab6.pre", 32'(bus.count), 2);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_status("ab6", 0, 0, 0, 1);
    tick();
    chk("ab6.after", 32'(bus.done), 0);

    // abort coinciding with the terminal edge
    load(2, 0);
    tick();
    chk("ab1.pre", 32'(bus.count), 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_status("ab1", 0, 0, 0, 1);
    tick();
    chk("ab1.after", 32'(bus.done), 0);

    // zero-length load
    load(0, 0);
    chk_status("ld0", 0, 0, 1, 1);
    tick();
    chk_status("ld0.after", 0, 0, 0, 1);

    // maximum load value
    load(255, 0);
    chk("ld255.ld", 32'(bus.count), 255);
    steps = 0;
    while (!bus.done && steps < 300) begin
      tick();
      steps++;
    end
    chk("ld255.steps", 32'(steps), 255);
    chk_status("ld255.term", 0, 0, 1, 1);

    // back-to-back loads with load_valid held
    bus.load_valid = 1'b1;
    bus.load_value = 8'd2;
    tick();
    chk("b2b.ld", 32'(bus.count), 2);
    tick();
    chk("b2b.c1", 32'(bus.count), 1);
    tick();
    chk_status("b2b.term", 0, 0, 1, 1);
    tick();
    chk_status("b2b.reld", 2, 1, 0, 0);
    bus.load_valid = 1'b0;
    tick();
    chk("b2b.c1b", 32'(bus.count), 1);

    // reset mid-run, on what would be the terminal edge
    reset = 1'b1;
    tick();
    chk_status("rst.run", 0, 0, 0, 1);
    reset = 1'b0;
    tick();
    chk_status("rst.after", 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter; the terminal-count side of the free-running up counter.
- Accepts a start value over a valid/ready handshake and decrements once per enabled cycle.
- Pulses `done` on reaching zero, with optional automatic reload for periodic ticks.
- Serves as the timeout/period generator for control logic that today polls the up counter.

Parameters:
- WIDTH, 8, width of load value and count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  start value offered.
- load_ready  output  1  block can accept a start value.
- load_value  input  WIDTH  start value, sampled on the handshake.
- auto_reload  input  1  at terminal count, reload instead of stopping; sampled on the terminal edge.
- enable  input  1  decrement permitted this cycle (pause when 0).
- abort  input  1  cancel a running countdown.
- count  output  WIDTH  current remaining count, registered.
- busy  output  1  countdown in progress (state RUN).
- done  output  1  one-cycle registered pulse at terminal count.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset has priority over all inputs. On reset: count=0, busy=0, done=0, load_ready=1, reload_reg=0, state=IDLE.
- load_ready = (state==IDLE), combinational from state. busy = (state==RUN).
- done defaults to 0 every cycle; it is 1 only in the cycle after a terminal event.
- States:
  - IDLE: a handshake occurs on an edge where load_valid && load_ready.
    - load_value != 0: count<=load_value, reload_reg<=load_value, go to RUN.
    - load_value == 0 (zero-length): count stays 0, done<=1, stay IDLE.
    - enable, abort and auto_reload are ignored in IDLE.
  - RUN: conditions are evaluated in priority order.
    - abort=1: count<=0, go to IDLE, no done pulse.
    - else enable=0: hold count and state.
    - else count>1: count<=count-1.
    - else count==1 (terminal): done<=1.
      - auto_reload=1: count<=reload_reg, stay RUN.
      - auto_reload=0: count<=0, go to IDLE.
  - load_valid during RUN is ignored and not queued. The source must hold load_valid until load_ready.
- Timing:
  - Load accepted at edge k gives count=N after edge k.
  - After N further enabled edges, done=1 for exactly one cycle.
  - With auto_reload held high, done pulses every N enabled cycles; count cycles N, N-1, …, 1, N.
- Count never underflows: no decrement at 0, and no wrap to all-ones.
- Terminal and load in the same cycle: in the done=1 cycle the state is already IDLE, so load_ready=1 and a new load is accepted on that edge. This allows back-to-back countdowns with no gap cycle.
- Abort on the terminal edge (count==1, enable=1) takes priority: no done, count=0.
- Max load value 2^WIDTH-1 counts down correctly; there is no internal width overflow.
- Reset mid-RUN: next cycle IDLE, count=0, no done pulse.

Test Plan:
- Reset, then load 5 with enable=1 and auto_reload=0 → count reads 5,4,3,2,1,0; done=1 only in the cycle count=0; busy falls with done; load_ready=1 thereafter.
- Load 3, auto_reload=1, enable=1 for 10 cycles → count 3,2,1,3,2,1,3,…; done pulses every 3rd cycle; busy stays 1.
- Load 4, enable toggling 1,0,0,1,1,1 → count 4,3,3,3,2,1,0; done exactly once; the hold cycles do not decrement.
- Load 6, abort at count=2 → next cycle count=0, IDLE, done never asserted. Repeat with abort and count==1 simultaneous → no done.
- Load 0 → done=1 the next cycle, busy never 1. Load 255 → done after exactly 255 enabled cycles.
- load_valid held high through a countdown of 2 → second load accepted on the done-cycle edge, no idle gap. Separately, reset asserted mid-RUN → count=0, done=0, load_ready=1 on the next cycle.
